// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle control unit.
// FP states exist only when MC_FPU_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_MULEX,
    S_MULWB
`ifdef MC_FPU_EN
    ,
    S_FPEX,
    S_FPWB
`endif
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_UMULL = 3'b101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_CP  = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] ASA_A  = 2'b00;
  localparam logic [1:0] ASA_PC = 2'b01;

  localparam logic [1:0] ASB_REG = 2'b00;
  localparam logic [1:0] ASB_IMM = 2'b01;
  localparam logic [1:0] ASB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_BR = 2'b10;

  function automatic logic dp_ok(input logic [3:0] cmd);
    return cmd inside {CMD_ADD, CMD_SUB, CMD_AND,
                       CMD_ORR, CMD_CMP};
  endfunction

  // Arithmetic ops own C/V; logical ops only touch N/Z.
  function automatic logic dp_arith(input logic [3:0] cmd);
    return cmd inside {CMD_ADD, CMD_SUB, CMD_CMP};
  endfunction

  function automatic logic [2:0] dp_alu(input logic [3:0] cmd);
    logic [2:0] a;
    unique case (cmd)
      CMD_ADD: a = ALU_ADD;
      CMD_SUB: a = ALU_SUB;
      CMD_CMP: a = ALU_SUB;
      CMD_AND: a = ALU_AND;
      CMD_ORR: a = ALU_ORR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control unit <-> datapath bundle.
// master = control unit (drives selects/enables), slave = datapath.
interface mc_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        FPUWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic        Src_64b;
  logic        RegSrc64b;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite,
    output FPUWrite, AdrSrc, RegSrc, ALUSrcA,
    output ALUSrcB, ResultSrc, ImmSrc, ALUControl,
    output Src_64b, RegSrc64b
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite,
    input  FPUWrite, AdrSrc, RegSrc, ALUSrcA,
    input  ALUSrcB, ResultSrc, ImmSrc, ALUControl,
    input  Src_64b, RegSrc64b
  );
endinterface

// File: rtl/mc_cond_unit.sv
// mc_cond_unit: NZCV flags register and ARM condition check.
// Ports: clk, reset (async high), cond, ALUFlags, FlagW[1]=NZ FlagW[0]=CV, CondEx.
module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  output logic       CondEx
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Flag writes are themselves conditional on the instruction's condition.
  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && CondEx)
      flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] && CondEx)
      flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= '0;
    else
      flags_q <= flags_d;
  end

  always_comb begin
    CondEx = 1'b0;
    unique case (cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = !z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = !c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = !n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = !v;
      4'b1000: CondEx = c && !z;
      4'b1001: CondEx = !c || z;
      4'b1010: CondEx = n == v;
      4'b1011: CondEx = n != v;
      4'b1100: CondEx = !z && (n == v);
      4'b1101: CondEx = z || (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM control FSM, Moore outputs, CondEx-gated writes.
// Ports: clk, reset (async high), bus (mc_ctrl_if.master). Optional FP path: MC_FPU_EN.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  state_e state_q;
  state_e state_d;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit;
  logic       s_bit;
  logic       l_bit;
  logic       long_mul;
  logic       is_mul;
  logic       is_cdp;
  logic       cond_ex;

  assign op       = bus.Instr[27:26];
  assign i_bit    = bus.Instr[25];
  assign cmd      = bus.Instr[24:21];
  assign s_bit    = bus.Instr[20];
  assign l_bit    = bus.Instr[20];
  assign long_mul = bus.Instr[23];

  assign is_mul = (op == OP_DP)
               && (bus.Instr[7:4] == 4'b1001)
               && (bus.Instr[27:24] == 4'b0000);

  assign is_cdp = (op == OP_CP)
               && (bus.Instr[25:24] == 2'b10)
               && !bus.Instr[4];

  logic unused_bits;
`ifdef MC_FPU_EN
  assign unused_bits = ^{bus.Instr[19:8], bus.Instr[3:0]};
`else
  assign unused_bits = ^{bus.Instr[19:8], bus.Instr[3:0], is_cdp};
`endif

  logic [1:0] flag_w;

  mc_cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (bus.Instr[31:28]),
    .ALUFlags (bus.ALUFlags),
    .FlagW    (flag_w),
    .CondEx   (cond_ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op == OP_MEM:
            state_d = S_MEMADR;
          op == OP_BR:
            state_d = S_BRANCH;
          is_mul:
            state_d = S_MULEX;
          op == OP_DP && i_bit:
            state_d = S_EXECI;
          op == OP_DP && !i_bit && !is_mul:
            state_d = S_EXECR;
`ifdef MC_FPU_EN
          is_cdp:
            state_d = S_FPEX;
`endif
          default:
            state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = l_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD: state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:
        state_d = dp_ok(cmd) ? S_ALUWB : S_FETCH;
      S_MULEX: state_d = S_MULWB;
`ifdef MC_FPU_EN
      S_FPEX: state_d = S_FPWB;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  logic       pc_w;
  logic       ir_w;
  logic       adr;
  logic [1:0] rsel;
  logic [1:0] asa;
  logic [1:0] asb;
  logic [1:0] res;
  logic [1:0] imm;
  logic [2:0] alu;
  logic       s64;
  logic       rs64;
  logic       reg_we;
  logic       mem_we;
  logic       br_we;
`ifdef MC_FPU_EN
  logic       fpu_we;
`endif

  always_comb begin
    pc_w   = 1'b0;
    ir_w   = 1'b0;
    adr    = 1'b0;
    rsel   = 2'b00;
    asa    = ASA_A;
    asb    = ASB_REG;
    res    = RES_ALUOUT;
    imm    = IMM_8;
    alu    = ALU_ADD;
    s64    = 1'b0;
    rs64   = 1'b0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    br_we  = 1'b0;
    flag_w = 2'b00;
`ifdef MC_FPU_EN
    fpu_we = 1'b0;
`endif
    unique case (state_q)
      S_FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        asa  = ASA_PC;
        asb  = ASB_4;
        res  = RES_ALU;
      end
      S_DECODE: begin
        asa  = ASA_PC;
        asb  = ASB_4;
        res  = RES_ALU;
        rsel = {op == OP_MEM, op == OP_BR};
      end
      S_MEMADR: begin
        asb = ASB_IMM;
        imm = IMM_12;
      end
      S_MEMRD: adr = 1'b1;
      S_MEMWB: begin
        res    = RES_DATA;
        reg_we = 1'b1;
      end
      S_MEMWR: begin
        adr    = 1'b1;
        mem_we = 1'b1;
      end
      S_EXECR: alu = dp_alu(cmd);
      S_EXECI: begin
        asb = ASB_IMM;
        imm = IMM_8;
        alu = dp_alu(cmd);
      end
      S_ALUWB: begin
        res    = RES_ALUOUT;
        reg_we = cmd != CMD_CMP;
        flag_w = {s_bit, s_bit && dp_arith(cmd)};
      end
      S_BRANCH: begin
        asb   = ASB_IMM;
        imm   = IMM_BR;
        res   = RES_ALU;
        br_we = 1'b1;
      end
      S_MULEX: begin
        rs64 = 1'b1;
        alu  = long_mul ? ALU_UMULL : ALU_MUL;
      end
      S_MULWB: begin
        rs64   = 1'b1;
        alu    = long_mul ? ALU_UMULL : ALU_MUL;
        s64    = long_mul;
        reg_we = 1'b1;
      end
`ifdef MC_FPU_EN
      S_FPEX: ;
      S_FPWB: fpu_we = 1'b1;
`endif
      default: ;
    endcase
  end

  // Fetch-side enables are unconditional; architectural writes wait on CondEx.
  assign bus.PCWrite    = pc_w | (br_we & cond_ex);
  assign bus.RegWrite   = reg_we & cond_ex;
  assign bus.MemWrite   = mem_we & cond_ex;
  assign bus.IRWrite    = ir_w;
  assign bus.AdrSrc     = adr;
  assign bus.RegSrc     = rsel;
  assign bus.ALUSrcA    = asa;
  assign bus.ALUSrcB    = asb;
  assign bus.ResultSrc  = res;
  assign bus.ImmSrc     = imm;
  assign bus.ALUControl = alu;
  assign bus.Src_64b    = s64;
  assign bus.RegSrc64b  = rs64;
`ifdef MC_FPU_EN
  assign bus.FPUWrite   = fpu_we & cond_ex;
`else
  assign bus.FPUWrite   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench for mc_control_unit.
// Per-instruction expected control words come from an instruction-level model.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       fpuw;
    logic       adr;
    logic [1:0] regsrc;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] rsrc;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       s64;
    logic       rs64;
  } ctl_t;

  typedef struct {
    ctl_t  w;
    string tag;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] mflags;

  function automatic bit cond_ok(input logic [3:0] cc,
                                 input logic [3:0] f);
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = c;
      4'h3: r = !c;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = c && !z;
      4'h9: r = !c || z;
      4'hA: r = n == v;
      4'hB: r = n != v;
      4'hC: r = !z && (n == v);
      4'hD: r = z || (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic ctl_t fetch_w();
    ctl_t w = '0;
    w.pcw = 1; w.irw = 1;
    w.asa = 2'b01; w.asb = 2'b10; w.rsrc = 2'b10;
    return w;
  endfunction

  // Expected control words for one instruction, issued cycle by cycle.
  task automatic run_instr(input logic [31:0] ins,
                           input logic [3:0] af,
                           input int cut);
    ctl_t  seq[$];
    string tg[$];
    ctl_t  w;
    bit    ce, mul, fp_ok, dp;
    logic [1:0] op;
    logic [3:0] cmd;
    int    n;
    ce  = cond_ok(ins[31:28], mflags);
    op  = ins[27:26];
    cmd = ins[24:21];
    mul = op == 2'b00 && ins[7:4] == 4'h9 && ins[27:24] == 4'h0;
`ifdef MC_FPU_EN
    fp_ok = ins[27:24] == 4'hE && !ins[4];
`else
    fp_ok = 0;
`endif
    dp = cmd inside {4'h4, 4'h2, 4'h0, 4'hC, 4'hA};
    seq.push_back(fetch_w()); tg.push_back("fetch");
    w = '0; w.asa = 2'b01; w.asb = 2'b10; w.rsrc = 2'b10;
    w.regsrc = {op == 2'b01, op == 2'b10};
    seq.push_back(w); tg.push_back("decode");
    if (op == 2'b10) begin
      w = '0; w.asb = 2'b01; w.imm = 2'b10; w.rsrc = 2'b10; w.pcw = ce;
      seq.push_back(w); tg.push_back("branch");
    end else if (op == 2'b01) begin
      w = '0; w.asb = 2'b01; w.imm = 2'b01;
      seq.push_back(w); tg.push_back("memadr");
      if (ins[20]) begin
        w = '0; w.adr = 1;
        seq.push_back(w); tg.push_back("memrd");
        w = '0; w.rsrc = 2'b01; w.regw = ce;
        seq.push_back(w); tg.push_back("memwb");
      end else begin
        w = '0; w.adr = 1; w.memw = ce;
        seq.push_back(w); tg.push_back("memwr");
      end
    end else if (mul) begin
      w = '0; w.rs64 = 1; w.alu = ins[23] ? 3'b101 : 3'b100;
      seq.push_back(w); tg.push_back("mulex");
      w.regw = ce; w.s64 = ins[23];
      seq.push_back(w); tg.push_back("mulwb");
    end else if (op == 2'b00) begin
      w = '0;
      if (ins[25]) w.asb = 2'b01;
      case (cmd)
        4'h2, 4'hA: w.alu = 3'b001;
        4'h0: w.alu = 3'b010;
        4'hC: w.alu = 3'b011;
        default: w.alu = 3'b000;
      endcase
      seq.push_back(w); tg.push_back("exec");
      if (dp) begin
        w = '0; w.regw = ce && cmd != 4'hA;
        seq.push_back(w); tg.push_back("aluwb");
      end
    end else if (fp_ok) begin
      w = '0;
      seq.push_back(w); tg.push_back("fpex");
      w.fpuw = ce;
      seq.push_back(w); tg.push_back("fpwb");
    end
    n = (cut > 0 && cut < seq.size()) ? cut : seq.size();
    for (int i = 0; i < n; i++) sbq.push_back('{seq[i], tg[i]});
    bus.Instr = ins;
    bus.ALUFlags = af;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    if (n == seq.size() && op == 2'b00 && !mul && dp && ins[20] && ce) begin
      if (cmd inside {4'h4, 4'h2, 4'hA}) mflags = af;
      else mflags[3:2] = af[3:2];
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{fetch_w(), "reset"});
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mflags = 4'h0;
  endtask

  initial begin : monitor
    exp_t e;
    ctl_t got;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        got = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite,
               bus.FPUWrite, bus.AdrSrc, bus.RegSrc, bus.ALUSrcA,
               bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl,
               bus.Src_64b, bus.RegSrc64b};
        total++;
        if (got !== e.w) begin
          bad++;
          $display("FAIL %s instr=%h got=%h want=%h",
                   e.tag, bus.Instr, got, e.w);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, got pending=%0d want 0",
             sbq.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ins;
    logic [3:0]  cmds [5];
    int          cut;
    cmds = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA};
    reset = 1'b1;
    bus.Instr = '0;
    bus.ALUFlags = '0;
    mflags = 4'h0;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(32'hE2821005, 4'h0, -1);
    run_instr(32'hE1510001, 4'b0100, -1);
    run_instr(32'h1AFFFFFE, 4'h0, -1);
    run_instr(32'hEAFFFFFE, 4'h0, -1);
    run_instr(32'hE5921004, 4'h0, -1);
    run_instr(32'hE0010392, 4'h0, -1);
    run_instr(32'hE0821392, 4'h0, -1);
    run_instr(32'hEE300A01, 4'h0, -1);

    run_instr(32'hE1510001, 4'b0100, -1);
    run_instr(32'hE5921004, 4'h0, 3);
    do_reset(2);
    run_instr(32'h0AFFFFFE, 4'h0, -1);

    repeat (400) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
      case ($urandom_range(0, 6))
        0: ins[27:26] = 2'b00;
        1: ins[27:26] = 2'b01;
        2: ins[27:26] = 2'b10;
        3: begin
          ins[27:24] = 4'h0;
          ins[7:4] = 4'h9;
        end
        4: begin
          ins[27:24] = 4'hE;
          ins[4] = 1'b0;
        end
        5: ins[27:26] = 2'b11;
        default: begin
          ins[27:25] = {2'b00, $urandom_range(0, 1) == 1};
          ins[24:21] = cmds[$urandom_range(0, 4)];
        end
      endcase
      cut = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : -1;
      run_instr(ins, 4'($urandom), cut);
      if (cut > 0) do_reset($urandom_range(1, 3));
    end

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
